div16_mitchell_seq: RTL and testbench

- Multi-cycle Mitchell log-domain approximate divider; the inverse operation to the team's Mitchell multiplier datapath.
- Takes a 16-bit dividend and an 8-bit divisor and encodes both to {characteristic, fraction}.
- Subtracts in the log domain, then antilog-decodes to a 16-bit integer quotient.
- Sits behind a valid/ready handshake so it can be dropped into streaming accelerator pipelines next to the multiplier.

---
 rtl/div16_mitchell_seq.sv | 158 +++++++++++++++
 tb/tb_div16_mitchell_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div16_mitchell_seq.sv
// Multi-cycle Mitchell log-domain approximate divider (16-bit / 8-bit) behind valid/ready.
// Define MITCHELL_DIV_ROUND_EN to round the quotient half-up instead of truncating it.
module div16_mitchell_seq #(
  parameter int FRAC_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic        div_by_zero
);

  localparam int M_W  = FRAC_W + 2;   // log-domain mantissa incl. integer and borrow bits
  localparam int SH_W = FRAC_W + 16;  // m < 2^(FRAC_W+1), shifted by at most 15
  localparam logic [M_W-1:0] M_ONE = {2'b01, {FRAC_W{1'b0}}};
  localparam logic [M_W-1:0] M_TWO = {2'b10, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ENC, S_SUB, S_DEC, S_HOLD} state_t;

  state_t state_q, state_d;

  logic [15:0]             op_a_q;
  logic [7:0]              op_b_q;
  logic [3:0]              k1_q, k2_q, k1_d, k2_d;
  logic [FRAC_W-1:0]       f1_q, f2_q, f1_d, f2_d;
  logic                    z1_q, z2_q;
  logic signed [5:0]       kd_q, kd_d, kd_raw;
  logic signed [M_W-1:0]   fd;
  logic [M_W-1:0]          m_q, m_d;
  logic [SH_W-1:0]         shifted;
  logic [15:0]             q_d;

  function automatic logic [3:0] lead_one(input logic [15:0] x);
    lead_one = '0;
    for (int i = 0; i < 16; i++)
      if (x[i]) lead_one = 4'(i);
  endfunction

  // Normalise the leading one to bit 15, then keep the FRAC_W bits below it (truncated).
  function automatic logic [FRAC_W-1:0] frac_of(input logic [15:0] x, input logic [3:0] k);
    return FRAC_W'((x << (4'd15 - k)) >> (15 - FRAC_W));
  endfunction

  assign k1_d = lead_one(op_a_q);
  assign k2_d = lead_one({8'd0, op_b_q});
  assign f1_d = frac_of(op_a_q, k1_d);
  assign f2_d = frac_of({8'd0, op_b_q}, k2_d);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    kd_raw = 6'(k1_q) - 6'(k2_q);
    fd     = $signed(M_W'(f1_q) - M_W'(f2_q));
    kd_d   = kd_raw;
    m_d    = M_ONE + $unsigned(fd);
    if (fd < 0) begin
      kd_d = kd_raw - 6'sd1;
      m_d  = M_TWO + $unsigned(fd);
    end
  end

`ifdef MITCHELL_DIV_ROUND_EN
  localparam int RND_W = SH_W + 1;
  localparam logic [RND_W-1:0] HALF = RND_W'(1) << (FRAC_W - 1);
  logic [RND_W-1:0] rounded;
  logic [16:0]      q_wide;
`endif

  always_comb begin
    shifted = SH_W'(m_q) << kd_q[3:0];
`ifdef MITCHELL_DIV_ROUND_EN
    rounded = {1'b0, shifted} + HALF;
    q_wide  = 17'(rounded >> FRAC_W);
    if (kd_q < 0)
      q_d = (kd_q == -6'sd1) ? 16'd1 : 16'd0;  // m/2^FRAC_W >= 1, so half of it rounds up
    else if (q_wide[16])
      q_d = 16'hFFFF;
    else
      q_d = q_wide[15:0];
`else
    q_d = (kd_q < 0) ? 16'd0 : 16'(shifted >> FRAC_W);
`endif
    if (z2_q)
      q_d = 16'hFFFF;
    else if (z1_q)
      q_d = 16'd0;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ENC;
      S_ENC:   state_d = S_SUB;
      S_SUB:   state_d = S_DEC;
      S_DEC:   state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_HOLD);
  end

  // Each pipeline step owns its registers; they only load in their own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      f1_q        <= '0;
      f2_q        <= '0;
      z1_q        <= 1'b0;
      z2_q        <= 1'b0;
      kd_q        <= '0;
      m_q         <= '0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_a_q <= dividend;
          op_b_q <= divisor;
        end
        S_ENC: begin
          k1_q <= k1_d;
          k2_q <= k2_d;
          f1_q <= f1_d;
          f2_q <= f2_d;
          z1_q <= (op_a_q == 16'd0);
          z2_q <= (op_b_q == 8'd0);
        end
        S_SUB: begin
          kd_q <= kd_d;
          m_q  <= m_d;
        end
        S_DEC: begin
          quotient    <= q_d;
          div_by_zero <= z2_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_mitchell_seq.sv
// Scoreboard bench for div16_mitchell_seq: directed vectors, backpressure, mid-op reset, random stream.
// Honours MITCHELL_DIV_ROUND_EN for the expected values.
module tb_div16_mitchell_seq;

  localparam int F = 7;

`ifdef MITCHELL_DIV_ROUND_EN
  localparam logic [15:0] Q_100_10 = 16'd11;
  localparam logic [15:0] Q_5_8    = 16'd1;
`else
  localparam logic [15:0] Q_100_10 = 16'd10;
  localparam logic [15:0] Q_5_8    = 16'd0;
`endif

  typedef struct {
    logic [15:0] q;
    logic        dbz;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic        dbz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic        div_by_zero;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   valid_seen = 0;
  bit   lat_done = 1'b0;
  bit   rand_ready = 1'b0;

  div16_mitchell_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: fixed-point logs, floor-divided difference, integer antilog.
  function automatic int msb_idx(input int x);
    int r = 0;
    for (int i = 0; i < 16; i++)
      if (x >= (1 << i)) r = i;
    return r;
  endfunction

  function automatic logic [15:0] ref_q(input int a, input int b);
    int k1, k2, f1, f2, d, kd, m;
    longint r;
    if (b == 0) return 16'hFFFF;
    if (a == 0) return 16'h0000;
    k1 = msb_idx(a);
    k2 = msb_idx(b);
    f1 = ((a - (1 << k1)) * (1 << F)) / (1 << k1);
    f2 = ((b - (1 << k2)) * (1 << F)) / (1 << k2);
    d  = (k1 - k2) * (1 << F) + f1 - f2;
    kd = (d >= 0) ? d / (1 << F) : -(((-d) + (1 << F) - 1) / (1 << F));
    m  = d - kd * (1 << F) + (1 << F);
`ifdef MITCHELL_DIV_ROUND_EN
    if (kd < -1) r = 0;
    else r = (longint'(m) * (longint'(1) << (kd + 1)) + (1 << F)) / (1 << (F + 1));
    if (r > 65535) r = 65535;
`else
    if (kd < 0) r = 0;
    else r = (longint'(m) * (longint'(1) << kd)) / (1 << F);
`endif
    return 16'(r);
  endfunction

  // Monitor: pops one expectation per output handshake; checks latency on first sight of each result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      valid_seen++;
      if (sb.size() == 0) begin
        check("unexpected out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!lat_done) begin
          check("latency", 32'(cyc - sb[0].acc_cyc), 32'd3);
          lat_done = 1'b1;
        end
        if (out_ready) begin
          mon_e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(mon_e.q));
          check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
          lat_done = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q, input logic dbz);
    int waited = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back('{q, dbz, cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[$] = '{
    '{16'd100,   8'd10,  Q_100_10,  1'b0},
    '{16'd96,    8'd7,   16'd14,    1'b0},
    '{16'd200,   8'd3,   16'd68,    1'b0},
    '{16'd4096,  8'd16,  16'd256,   1'b0},
    '{16'd5,     8'd0,   16'hFFFF,  1'b1},
    '{16'd0,     8'd9,   16'd0,     1'b0},
    '{16'd3,     8'd200, 16'd0,     1'b0},
    '{16'd65535, 8'd1,   16'd65280, 1'b0},  // 1.1111111b * 2^15
    '{16'd0,     8'd0,   16'hFFFF,  1'b1},
    '{16'd255,   8'd255, 16'd1,     1'b0},
    '{16'd1,     8'd1,   16'd1,     1'b0},
    '{16'd128,   8'd2,   16'd64,    1'b0},
    '{16'd5,     8'd8,   Q_5_8,     1'b0}
  };

  initial begin
    int seen;
    int waited;
    logic [15:0] a;
    logic [7:0]  b;

    #2;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz);
    drain("directed drained");

    // Backpressure: result held, inputs ignored, then release.
    out_ready = 1'b0;
    send(16'd100, 8'd10, Q_100_10, 1'b0);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("out_valid under backpressure", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        dividend = 16'd7;
        divisor  = 8'd1;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold quotient", 32'(quotient), 32'(Q_100_10));
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    check("hold out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle after handshake", 32'(in_ready), 32'd1);
    check("out_valid cleared", 32'(out_valid), 32'd0);
    send(16'd4096, 8'd16, 16'd256, 1'b0);
    drain("backpressure drained");

    // Reset while in SUB aborts the operation.
    dividend = 16'd200;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    seen = valid_seen;
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no result after abort", 32'(valid_seen - seen), 32'd0);

    // Back-to-back stream with random backpressure against the reference model.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a = 16'd0;
      if ($urandom_range(0, 15) == 0) b = 8'd0;
      if ($urandom_range(0, 7) == 0) a = 16'd1 << $urandom_range(0, 15);
      send(a, b, ref_q(int'(a), int'(b)), (b == 8'd0));
    end
    @(posedge clk);
    rand_ready = 1'b0;
    #2 out_ready = 1'b1;
    drain("stream drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
